// File: rtl/kgp_io_pkg.sv
// Shared types and helpers for the KGP board-level I/O blocks.
// Holds the sequencer state encoding, line-format constants and the hex-to-ASCII mapping.
package kgp_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [7:0]  ASCII_CR   = 8'h0D;
    localparam logic [7:0]  ASCII_LF   = 8'h0A;
    localparam int unsigned LINE_BYTES = 6;
    localparam int unsigned BIDX_W     = 3;
    localparam int unsigned VAL_W      = 16;

    // Uppercase hex digit for one nibble
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Byte idx (0..5) of the text line "HHHH\r\n" for value v
    function automatic logic [7:0] line_byte(input logic [VAL_W-1:0] v,
                                             input logic [BIDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = nibble_to_ascii(v[15:12]);
            3'd1:    b = nibble_to_ascii(v[11:8]);
            3'd2:    b = nibble_to_ascii(v[7:4]);
            3'd3:    b = nibble_to_ascii(v[3:0]);
            3'd4:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter with back-to-back chaining.
// done pulses in the last cycle of the stop bit; a start in that cycle begins the next start bit with no gap.
module uart_byte_tx
    import kgp_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    state_t            st, st_n;
    logic [BAUD_W-1:0] baud_cnt, baud_n;
    logic [2:0]        bit_cnt, bit_n;
    logic [7:0]        sh, sh_n;
    logic              tx_q, tx_n;
    logic              wrap_c;

    assign tx     = tx_q;
    assign wrap_c = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            tx_q     <= 1'b1;
        end else begin
            st       <= st_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            sh       <= sh_n;
            tx_q     <= tx_n;
        end
    end

    // Bit sequencing; baud counter advances every cycle while a byte is in flight
    always_comb begin
        st_n   = st;
        baud_n = baud_cnt;
        bit_n  = bit_cnt;
        sh_n   = sh;
        tx_n   = tx_q;
        done   = 1'b0;
        case (st)
            IDLE: begin
                baud_n = '0;
                if (start) begin
                    st_n = START;
                    sh_n = data;
                    tx_n = 1'b0;
                end
            end
            START: begin
                baud_n = baud_cnt + BAUD_W'(1);
                if (wrap_c) begin
                    baud_n = '0;
                    bit_n  = '0;
                    st_n   = DATA;
                    tx_n   = sh[0];
                end
            end
            DATA: begin
                baud_n = baud_cnt + BAUD_W'(1);
                if (wrap_c) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        st_n = STOP;
                        tx_n = 1'b1;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                        sh_n  = {1'b0, sh[7:1]};
                        tx_n  = sh[1];
                    end
                end
            end
            STOP: begin
                baud_n = baud_cnt + BAUD_W'(1);
                if (wrap_c) begin
                    baud_n = '0;
                    bit_n  = '0;
                    done   = 1'b1;
                    if (start) begin
                        st_n = START;
                        sh_n = data;
                        tx_n = 1'b0;
                    end else begin
                        st_n = IDLE;
                        tx_n = 1'b1;
                    end
                end
            end
            default: begin
                st_n   = IDLE;
                baud_n = '0;
                bit_n  = '0;
                tx_n   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/kgp_out_reporter.sv
// Watches the core's out bus and prints each new value as "HHHH\r\n" on a UART pin.
// Change detection, snapshot and byte sequencing live here; bit timing lives in uart_byte_tx.
module kgp_out_reporter
    import kgp_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] out_val,
    output logic             tx,
    output logic             busy
);

    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(LINE_BYTES - 1);

    // IDLE waits for a trigger; START means a line byte is in flight in the transmitter
    state_t            st, st_n;
    logic [VAL_W-1:0]  in_q;
    logic [VAL_W-1:0]  last_sent, last_sent_n;
    logic [VAL_W-1:0]  snap, snap_n;
    logic              pending, pending_n;
    logic [BIDX_W-1:0] bidx, bidx_n;
    logic              busy_q, busy_n;
    logic              trigger_c;
    logic              start_c;
    logic [7:0]        byte_c;
    logic              done_c;

    assign busy      = busy_q;
    assign trigger_c = pending || (in_q != last_sent);

    // Unreset capture so the value held during reset is already visible at release
    always_ff @(posedge clk) begin
        in_q <= out_val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            last_sent <= '0;
            snap      <= '0;
            pending   <= 1'b1;
            bidx      <= '0;
            busy_q    <= 1'b0;
        end else begin
            st        <= st_n;
            last_sent <= last_sent_n;
            snap      <= snap_n;
            pending   <= pending_n;
            bidx      <= bidx_n;
            busy_q    <= busy_n;
        end
    end

    // Load of the next byte is folded into the trigger cycle or the final stop-bit cycle
    always_comb begin
        st_n        = st;
        last_sent_n = last_sent;
        snap_n      = snap;
        pending_n   = pending;
        bidx_n      = bidx;
        busy_n      = busy_q;
        start_c     = 1'b0;
        byte_c      = line_byte(snap, bidx);
        case (st)
            IDLE: begin
                if (trigger_c) begin
                    snap_n      = in_q;
                    last_sent_n = in_q;
                    pending_n   = 1'b0;
                    bidx_n      = '0;
                    start_c     = 1'b1;
                    byte_c      = line_byte(in_q, '0);
                    busy_n      = 1'b1;
                    st_n        = START;
                end
            end
            START: begin
                if (done_c) begin
                    if (bidx == BIDX_LAST) begin
                        bidx_n = '0;
                        busy_n = 1'b0;
                        st_n   = IDLE;
                    end else begin
                        bidx_n  = bidx + BIDX_W'(1);
                        start_c = 1'b1;
                        byte_c  = line_byte(snap, bidx + BIDX_W'(1));
                    end
                end
            end
            default: begin
                bidx_n = '0;
                busy_n = 1'b0;
                st_n   = IDLE;
            end
        endcase
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .start(start_c),
        .data (byte_c),
        .tx   (tx),
        .done (done_c)
    );

endmodule

// File: tb/tb_kgp_out_reporter.sv
// Scoreboard bench for kgp_out_reporter: a timing-level reference predicts lines and busy,
// a UART monitor decodes tx mid-bit and compares each received line against the queue.
module tb_kgp_out_reporter;

    localparam int unsigned CPB      = 4;
    localparam int          LINE_CYC = 60 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] out_val = 16'h0000;
    logic        tx;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    kgp_out_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst    (rst),
        .out_val(out_val),
        .tx     (tx),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // ASCII text of the expected line, built from the line format
    function automatic logic [7:0] exp_byte(input logic [15:0] v, input int i);
        logic [3:0] nib;
        if (i == 4) return 8'h0D;
        if (i == 5) return 8'h0A;
        nib = 4'((v >> (12 - 4 * i)) & 16'hF);
        return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h41 + 8'(nib) - 8'd10);
    endfunction

    // Reference: input register, last reported value, and remaining line time
    logic [15:0] m_inq;
    logic [15:0] m_last;
    bit          m_pend;
    int          m_left;
    logic [15:0] exp_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_last = 16'h0000;
            m_pend = 1'b1;
            m_left = 0;
            exp_q.delete();
            m_inq  = out_val;
        end else begin
            if (m_left > 0) begin
                m_left--;
            end else if (m_pend || (m_inq != m_last)) begin
                exp_q.push_back(m_inq);
                m_last = m_inq;
                m_pend = 1'b0;
                m_left = LINE_CYC;
            end
            m_inq = out_val;
        end
    end

    // UART monitor: mc counts cycles from the first start-bit cycle
    int         mc = -1;
    logic [7:0] sh;
    logic [7:0] line_b[$];
    int         lines_seen = 0;

    always @(negedge clk) begin
        if (!rst) begin
            mc = -1;
            line_b.delete();
        end else begin
            check("busy", {31'b0, busy}, {31'b0, (m_left > 0)});
            if (mc < 0 && tx == 1'b0) begin
                mc = 0;
                check("start_in_line", {31'b0, (m_left > 0)}, 32'd1);
            end
            if (mc >= 0) begin
                if (mc == 2) begin
                    check("start_bit", {31'b0, tx}, 32'd0);
                end else if (mc >= 6 && mc <= 34 && ((mc - 6) % 4) == 0) begin
                    sh[(mc - 6) / 4] = tx;
                end else if (mc == 38) begin
                    check("stop_bit", {31'b0, tx}, 32'd1);
                    line_b.push_back(sh);
                    if (line_b.size() == 6) begin
                        lines_seen++;
                        if (exp_q.size() == 0) begin
                            check("unexpected_line", 32'd1, 32'd0);
                        end else begin
                            logic [15:0] v;
                            v = exp_q.pop_front();
                            for (int i = 0; i < 6; i++)
                                check($sformatf("line_%04h_byte%0d", v, i),
                                      {24'b0, line_b[i]}, {24'b0, exp_byte(v, i)});
                        end
                        line_b.delete();
                    end
                end
                mc = (mc == 38) ? -1 : mc + 1;
            end
        end
    end

    task automatic drive(input logic [15:0] v);
        @(posedge clk);
        #1 out_val = v;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (!(m_left == 0 && mc < 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int cnt;
        logic [15:0] pool[4];

        // Reset release with 0000
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b1;
        k = 0;
        while (busy !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        check("first_line_started", {31'b0, busy}, 32'd1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin @(negedge clk); cnt++; end
        check("busy_len", cnt, LINE_CYC);
        wait_idle(2000);
        check("tx_idle_after", {31'b0, tx}, 32'd1);

        // Hex digits and start latency
        repeat (5) @(posedge clk);
        drive(16'hBEEF);
        k = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (tx == 1'b0 && k == 0) k = i;
        end
        check("beef_latency", k, 2);

        // Coalesce changes made during the BEEF line
        repeat (40) @(posedge clk);
        drive(16'h0001);
        repeat (30) @(posedge clk);
        drive(16'h0002);
        repeat (30) @(posedge clk);
        drive(16'h0003);
        k = 0;
        while (busy === 1'b1 && k < 1000) begin @(posedge clk); #1; k++; end
        k = 0;
        while (busy === 1'b0 && k < 10) begin @(posedge clk); #1; k++; end
        check("followup_gap", k, 1);
        wait_idle(2000);

        // Revert to reported value during the line
        drive(16'h1234);
        repeat (30) @(posedge clk);
        drive(16'h5678);
        repeat (30) @(posedge clk);
        drive(16'h1234);
        wait_idle(2000);
        cnt = 0;
        repeat (300) begin @(negedge clk); if (busy) cnt++; end
        check("revert_no_line", cnt, 0);

        // Stable value
        drive(16'h00FF);
        repeat (5) @(posedge clk);
        wait_idle(2000);
        cnt = 0;
        repeat (1000) begin @(negedge clk); if (!tx) cnt++; end
        check("stable_quiet", cnt, 0);

        // Reset during DATA of byte 2
        drive(16'h2222);
        k = 0;
        while (tx !== 1'b0 && k < 10) begin @(posedge clk); #1; k++; end
        repeat (2 * 10 * CPB + CPB + 3 * CPB) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_tx", {31'b0, tx}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        out_val = 16'h00A5;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        wait_idle(2000);

        // Randomized values with repeats and reverts
        pool[0] = 16'h1234;
        pool[1] = 16'hABCD;
        pool[2] = 16'h00A5;
        for (int it = 0; it < 25; it++) begin
            pool[3] = 16'($urandom);
            drive(pool[$urandom_range(0, 3)]);
            repeat ($urandom_range(1, 300)) @(posedge clk);
        end
        repeat (5) @(posedge clk);
        wait_idle(4000);
        check("exp_queue_empty", exp_q.size(), 0);
        check("lines_seen_min", {31'b0, (lines_seen >= 6)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kgp_out_reporter.md
# kgp_out_reporter

Consumer for the processor's 16-bit `out` port. It watches the value the KGPRISC core drives on `out`, and each time the value changes it serialises it as a 4-digit uppercase hex ASCII line ("1A2F\r\n") on an 8N1 UART transmit pin. It sits on the board top level next to the core, so the program's results can be logged on a host terminal instead of read off LEDs.

## Interface
- `CLKS_PER_BIT`, default 868 — clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `clk`  in  1  — system clock, same clock as the core.
- `rst`  in  1  — asynchronous, active-low reset.
- `out_val`  in  16  — the core's `out` bus, synchronous to `clk`.
- `tx`  out  1  — UART serial output; idle high.
- `busy`  out  1  — high while a line is being transmitted.

## Operation
- `in_q`: register that captures `out_val` every cycle.
- `last_sent`: 16-bit snapshot of the most recently reported value.
- `pending`: flag. Reset sets it to 1, so the first value after reset is always reported.
- Report trigger, evaluated only in IDLE: `pending` = 1 or `in_q` ≠ `last_sent`.
  - On trigger: `snap` ← `in_q`, `last_sent` ← `in_q`, `pending` ← 0, then start the line.
- Line format, 6 bytes in order:
  - hex(`snap[15:12]`), hex(`snap[11:8]`), hex(`snap[7:4]`), hex(`snap[3:0]`), 0x0D, 0x0A.
  - hex(n): n+0x30 for n ≤ 9; n+0x37 for n ≥ 10, giving uppercase A–F.
- Byte framing:
  - start bit 0, then 8 data bits LSB first, then 1 stop bit of 1.
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - No idle gap between the 6 bytes of a line.
- Sequencer FSM:
  - IDLE → LOAD on trigger. LOAD picks the byte for index `bidx` (0..5).
  - LOAD → START → DATA (bit counter 0..7) → STOP.
  - STOP → LOAD if `bidx` < 5 (then `bidx`++); STOP → IDLE if `bidx` = 5.
  - LOAD takes zero bit-time: it is merged with the last cycle of the previous STOP, or with the trigger cycle.
- Changes to `out_val` during a line:
  - They never alter `snap`.
  - Intermediate values are coalesced. On return to IDLE, only the current `in_q` is compared with `last_sent`.
  - If `out_val` changes and reverts to `last_sent` during a line, nothing is reported.
- Reset mid-line aborts immediately: `tx` goes to 1 and the partial byte is lost. After release, the value present is reported (`pending` = 1).

## Timing
- Reset values: `tx` = 1, `busy` = 0, FSM = IDLE, `bidx` = 0, bit/baud counters = 0, `last_sent` = 0, `snap` = 0, `pending` = 1.
- Latency: `out_val` change at edge N → `in_q` at N+1 → trigger evaluated in cycle N+1 → `tx` = 0 (start bit) and `busy` = 1 from edge N+2.
- One line = 60 × `CLKS_PER_BIT` cycles.
  - `busy` falls on the same edge the final stop bit ends.
  - The earliest next start bit is one cycle after that (IDLE evaluation cycle).
- `tx` and `busy` are registered outputs with no combinational path from `out_val`.
- Baud counter counts 0..`CLKS_PER_BIT`−1 and wraps.
  - Width: $clog2(`CLKS_PER_BIT`).
  - A bit advances on the wrap.

## Structure
- Package `kgp_io_pkg` holds:
  - FSM state enum (IDLE, LOAD, START, DATA, STOP);
  - constants ASCII_CR = 8'h0D, ASCII_LF = 8'h0A, LINE_BYTES = 6;
  - a nibble-to-ASCII function.
- One sub-module is natural: `uart_byte_tx`.
  - Ports: `clk`, `rst`, `start`, `data[7:0]`, `tx`, `done`.
  - Owns the baud and bit counters.
- `kgp_out_reporter` keeps change detection, the snapshot, and byte sequencing.

## Test plan
Run the bench with `CLKS_PER_BIT` = 4; the UART monitor samples mid-bit.
- **Reset release.** `out_val` = 16'h0000, release `rst` → line "0000\r\n" (30 30 30 30 0D 0A); `busy` high for exactly 240 cycles; `tx` = 1 afterwards.
- **Hex digits.** Set `out_val` = 16'hBEEF after idle → "BEEF\r\n" (42 45 45 46 0D 0A); first start bit two edges after the change.
- **Coalescing.** During a line, drive 16'h0001, then 16'h0002, then 16'h0003 → exactly one follow-up line, "0003\r\n", starting one cycle after `busy` falls.
- **Revert to reported value.** Report 16'h1234; during that line toggle to 16'h5678 and back to 16'h1234 → no second line; `busy` stays 0.
- **Stable value.** Hold 16'h00FF for 1000 cycles after its line → no further `tx` activity.
- **Reset mid-line.** Assert `rst` during the DATA bits of byte 2 → `tx` = 1 and `busy` = 0 immediately (asynchronously); after release with `out_val` = 16'h00A5 → "00A5\r\n".
